lsu_bus_if: RTL and testbench

//  Load/store unit between datapath and data-memory bus; sits directly downstream of the datapath.

---
 rtl/lsu_bus_if.sv | 146 ++++++++++++++
 tb/tb_lsu_bus_if.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - single-outstanding load/store unit driving a req/ack data bus
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu_bus_if #(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_is_lw,
  input  logic          i_is_lb,
  input  logic          i_is_sw,
  input  logic [AW-1:0] i_d_ad,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic          o_bus_req,
  output logic          o_bus_we,
  output logic [AW-1:0] o_bus_ad,
  output logic [1:0]    o_bus_be,
  output logic [DW-1:0] o_bus_wd,
  input  logic          i_bus_ack,
  input  logic [DW-1:0] i_bus_rd
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic          lb_q, lb_d;
  logic [AW-1:0] ad_q, ad_d;
  logic [1:0]    be_q, be_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          accept;
  logic          in_bus;
`ifdef LSU_TIMEOUT_EN
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  assign accept = (state_q == S_IDLE) && i_req && (i_is_sw || i_is_lw || i_is_lb);
  assign in_bus = (state_q == S_BUS);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    lb_d    = lb_q;
    ad_d    = ad_q;
    be_d    = be_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUS;
          we_d    = i_is_sw;
          lb_d    = !i_is_sw && !i_is_lw;
          ad_d    = {i_d_ad[AW-1:1], 1'b0};
          // Word ops always use both lanes; byte loads pick the lane from address bit 0.
          be_d    = (i_is_sw || i_is_lw) ? 2'b11 : (i_d_ad[0] ? 2'b10 : 2'b01);
          wd_d    = i_wdata;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = 8'd0;
          err_d   = 1'b0;
`endif
        end
      end
      S_BUS: begin
        if (i_bus_ack) begin
          state_d = S_DONE;
          if (!we_q) begin
            if (!lb_q)
              rdata_d = i_bus_rd;
            else if (be_q[1])
              rdata_d = {{(DW/2){1'b0}}, i_bus_rd[DW-1:DW/2]};
            else
              rdata_d = {{(DW/2){1'b0}}, i_bus_rd[DW/2-1:0]};
          end
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          if (!we_q) rdata_d = DW'(16'hDEAD);
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      lb_q    <= 1'b0;
      ad_q    <= '0;
      be_q    <= 2'b00;
      wd_q    <= '0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      lb_q    <= lb_d;
      ad_q    <= ad_d;
      be_q    <= be_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Bus outputs are gated by state so they read zero whenever no transfer is in flight.
  assign o_rdata   = rdata_q;
  assign o_busy    = accept || in_bus;
  assign o_done    = (state_q == S_DONE);
  assign o_bus_req = in_bus;
  assign o_bus_we  = in_bus && we_q;
  assign o_bus_ad  = in_bus ? ad_q : '0;
  assign o_bus_be  = in_bus ? be_q : 2'b00;
  assign o_bus_wd  = in_bus ? wd_q : '0;
`ifdef LSU_TIMEOUT_EN
  assign o_err     = o_done && err_q;
`else
  assign o_err     = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb/tb_lsu_bus_if.sv - scoreboard bench for lsu_bus_if
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_is_lw = 1'b0, i_is_lb = 1'b0, i_is_sw = 1'b0;
  logic [15:0] i_d_ad = '0, i_wdata = '0, i_bus_rd = '0;
  logic        i_bus_ack = 1'b0;
  logic [15:0] o_rdata, o_bus_ad, o_bus_wd;
  logic        o_busy, o_done, o_err, o_bus_req, o_bus_we;
  logic [1:0]  o_bus_be;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_rd = 16'h0000;
  int          vectors = 0;
  int          miss = 0;
  int          done_cnt = 0;

  lsu_bus_if #(.AW(16), .DW(16), .TIMEOUT_CYC(255)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req(i_req), .i_is_lw(i_is_lw), .i_is_lb(i_is_lb), .i_is_sw(i_is_sw),
    .i_d_ad(i_d_ad), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_ad(o_bus_ad),
    .o_bus_be(o_bus_be), .o_bus_wd(o_bus_wd),
    .i_bus_ack(i_bus_ack), .i_bus_rd(i_bus_rd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (o_done === 1'b1) done_cnt++;

  // kind: 0 = lw, 1 = lb, 2 = sw. inject drives a stray lw request during BUS and DONE.
  task automatic do_op(input int kind, input logic [15:0] ad, input logic [15:0] wd,
                       input int waits, input logic [15:0] rd, input bit inject);
    logic [15:0] ead;
    logic [1:0]  ebe;
    exp_t        e;
    ead = {ad[15:1], 1'b0};
    ebe = (kind == 1) ? (ad[0] ? 2'b10 : 2'b01) : 2'b11;
    if (kind == 0) model_rd = rd;
    else if (kind == 1) model_rd = ad[0] ? {8'h00, rd[15:8]} : {8'h00, rd[7:0]};
    e.rdata = model_rd;
    e.err   = 1'b0;
    sb.push_back(e);

    @(posedge clk); #1;
    i_req = 1'b1; i_is_lw = (kind == 0); i_is_lb = (kind == 1); i_is_sw = (kind == 2);
    i_d_ad = ad; i_wdata = wd;
    #1;
    vectors++;
    if ({o_busy, o_bus_req, o_done} !== 3'b100) begin
      miss++; $display("FAIL accept busy/req/done got %b want 100", {o_busy, o_bus_req, o_done});
    end
    @(posedge clk); #1;
    i_req = inject; i_is_lw = inject; i_is_lb = 1'b0; i_is_sw = 1'b0;
    i_d_ad = 16'hFFFF; i_wdata = 16'h0F0F;
    for (int w = 0; w <= waits; w++) begin
      i_bus_ack = (w == waits);
      i_bus_rd  = (w == waits) ? rd : 16'h5A5A;
      #1;
      vectors++;
      if ({o_bus_req, o_busy, o_done, o_bus_we, o_bus_ad, o_bus_be} !== {3'b110, kind == 2, ead, ebe}) begin
        miss++;
        $display("FAIL bus_cycle%0d req/busy/done/we/ad/be got %b_%h_%b want %b_%h_%b", w,
                 {o_bus_req, o_busy, o_done, o_bus_we}, o_bus_ad, o_bus_be,
                 {3'b110, kind == 2}, ead, ebe);
      end
      if (kind == 2) begin
        vectors++;
        if (o_bus_wd !== wd) begin
          miss++; $display("FAIL bus_wd cycle%0d got %h want %h", w, o_bus_wd, wd);
        end
      end
      @(posedge clk); #1;
    end
    i_bus_ack = 1'b0;
    e = sb.pop_front();
    vectors++;
    if ({o_done, o_err, o_busy, o_bus_req} !== 4'b1000) begin
      miss++; $display("FAIL done_cycle done/err/busy/req got %b want 1000", {o_done, o_err, o_busy, o_bus_req});
    end
    vectors++;
    if (o_rdata !== e.rdata) begin
      miss++; $display("FAIL rdata got %h want %h", o_rdata, e.rdata);
    end
    i_req = 1'b0; i_is_lw = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    vectors++;
    if ({o_rdata, o_busy, o_done, o_err, o_bus_req, o_bus_we, o_bus_ad, o_bus_be, o_bus_wd} !== 55'd0) begin
      miss++; $display("FAIL reset outputs got nonzero rdata=%h req=%b ad=%h", o_rdata, o_bus_req, o_bus_ad);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_rd = 16'h0000;
  endtask

  task automatic test_ignored;
    logic [15:0] saved;
    saved = o_rdata;
    @(posedge clk); #1;
    i_req = 1'b1;
    #1;
    vectors++;
    if (o_busy !== 1'b0) begin miss++; $display("FAIL noflag_busy got %b want 0", o_busy); end
    i_bus_ack = 1'b1; i_bus_rd = 16'h7777;
    @(posedge clk); #1;
    i_req = 1'b0; i_bus_ack = 1'b0;
    vectors++;
    if ({o_bus_req, o_busy, o_done} !== 3'b000) begin
      miss++; $display("FAIL noflag_state req/busy/done got %b want 000", {o_bus_req, o_busy, o_done});
    end
    @(posedge clk); #1;
    vectors++;
    if (o_done !== 1'b0 || o_rdata !== saved) begin
      miss++; $display("FAIL idle_ack done/rdata got %b/%h want 0/%h", o_done, o_rdata, saved);
    end
  endtask

  task automatic test_reset_mid_bus;
    int n0;
    @(posedge clk); #1;
    i_req = 1'b1; i_is_lw = 1'b1; i_d_ad = 16'h0040;
    @(posedge clk); #1;
    i_req = 1'b0; i_is_lw = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (o_bus_req !== 1'b1) begin miss++; $display("FAIL midbus_req got %b want 1", o_bus_req); end
    n0 = done_cnt;
    rst_n = 1'b0;
    #1;
    model_rd = 16'h0000;
    vectors++;
    if ({o_bus_req, o_busy, o_rdata} !== 18'd0) begin
      miss++; $display("FAIL async_reset req/busy/rdata got %b/%b/%h want 0/0/0000", o_bus_req, o_busy, o_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if (done_cnt !== n0) begin miss++; $display("FAIL reset_no_done got %0d pulses want 0", done_cnt - n0); end
    do_op(0, 16'h0040, 16'h0000, 1, 16'hC0DE, 1'b0);
  endtask

  task automatic test_back_to_back;
    int n0;
    @(posedge clk); #1;
    n0 = done_cnt;
    do_op(0, 16'h0200, 16'h0000, 2, 16'h1357, 1'b1);
    do_op(2, 16'h0202, 16'h2468, 0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    vectors++;
    if (done_cnt - n0 !== 2) begin miss++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - n0); end
    vectors++;
    if ({o_busy, o_bus_req} !== 2'b00) begin miss++; $display("FAIL b2b_idle busy/req got %b want 00", {o_busy, o_bus_req}); end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    int n;
    @(posedge clk); #1;
    i_req = 1'b1; i_is_lw = 1'b1; i_d_ad = 16'h0020;
    n = 0;
    while (n < 400 && o_done !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin i_req = 1'b0; i_is_lw = 1'b0; end
    end
    vectors++;
    if (n !== 257) begin miss++; $display("FAIL timeout_latency got %0d want 257", n); end
    vectors++;
    if ({o_err, o_done, o_bus_req, o_rdata} !== {3'b110, 16'hDEAD}) begin
      miss++; $display("FAIL timeout_result err/done/req/rdata got %b/%h want 110/dead",
                       {o_err, o_done, o_bus_req}, o_rdata);
    end
    model_rd = 16'hDEAD;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset;
    do_op(0, 16'h0040, 16'h0000, 0, 16'h1234, 1'b0);
    do_op(2, 16'h0102, 16'hBEEF, 3, 16'h0000, 1'b0);
    do_op(1, 16'h0011, 16'h0000, 1, 16'hA55A, 1'b0);
    do_op(1, 16'h0010, 16'h0000, 0, 16'hA55A, 1'b0);
    do_op(0, 16'h0043, 16'h0000, 0, 16'h8001, 1'b0);
    test_ignored;
    test_reset_mid_bus;
    test_back_to_back;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got hang want finish");
    $fatal(1, "simulation time limit");
  end

endmodule
